// File: rtl/usb_sie_rx_packet_buffer.sv
// rtl/usb_sie_rx_packet_buffer.sv - packet-granular SIE receive buffer with atomic commit and rollback
module usb_sie_rx_packet_buffer #(
    parameter int DEPTH     = 64,
    parameter int PKT_SLOTS = 4,
    parameter int CNT_W     = 8
) (
    input  logic                         clk48,
    input  logic                         RST_N,
    input  logic                         flush,
    input  logic [7:0]                   rxData,
    input  logic                         rxDataValid,
    input  logic                         rxIsLastByte,
    input  logic                         keepPacket,
    output logic                         rxAcceptNewData,
    output logic [7:0]                   outData,
    output logic                         outValid,
    output logic                         outIsLastByte,
    input  logic                         outReady,
    output logic [$clog2(PKT_SLOTS):0]   pktCount,
    output logic [CNT_W-1:0]             droppedCount,
    output logic                         dropPulse,
    output logic                         overflowPulse
);

    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(PKT_SLOTS);
    localparam logic [AW:0] L_DEPTH = (AW+1)'(DEPTH);
    localparam logic [SW:0] L_SLOTS = (SW+1)'(PKT_SLOTS);

    // Byte storage and per-packet end addresses; neither needs a reset value.
    logic [7:0]  r_mem  [DEPTH];
    logic [AW:0] r_endq [PKT_SLOTS];

    // wr: tentative write head, cm: last committed boundary, rd: read head.
    logic [AW:0]      r_wr, r_cm, r_rd;
    logic [SW-1:0]    r_qwr, r_qrd;
    logic [SW:0]      r_pkt_cnt;
    logic             r_in_pkt, r_ovf, r_discard, r_accept;
    logic             r_drop_pulse, r_ovf_pulse;
    logic [CNT_W-1:0] r_dropped;

    logic [AW:0] w_used;
    logic        w_full, w_acc, w_active, w_store, w_last;
    logic        w_out_valid, w_out_last, w_rd_adv, w_pop;
    logic [SW:0] w_cnt_after_pop;
    logic        w_slot_free, w_commit, w_drop, w_ovf_cause;

    assign w_used      = r_wr - r_rd;
    assign w_full      = (w_used == L_DEPTH);
    assign w_acc       = rxDataValid && r_accept;
    // Bytes arriving while a flushed packet drains are not part of any live packet.
    assign w_active    = w_acc && !r_discard;
    assign w_store     = w_active && !w_full && !r_ovf;
    assign w_last      = w_active && rxIsLastByte;

    assign w_out_valid = (r_pkt_cnt != '0);
    assign w_out_last  = w_out_valid && (r_rd == r_endq[r_qrd]);
    assign w_rd_adv    = w_out_valid && outReady;
    assign w_pop       = w_rd_adv && w_out_last;

    // A packet finishing its read this cycle frees its slot for a same-cycle commit.
    assign w_cnt_after_pop = r_pkt_cnt - (SW+1)'(w_pop);
    assign w_slot_free     = (w_cnt_after_pop < L_SLOTS);
    assign w_commit        = w_last && keepPacket && !r_ovf && w_store && w_slot_free;
    assign w_drop          = w_last && !w_commit;
    assign w_ovf_cause     = r_ovf || w_full || !w_slot_free;

    assign rxAcceptNewData = r_accept;
    assign outValid        = w_out_valid;
    assign outIsLastByte   = w_out_last;
    // Gated so the data port reads zero whenever nothing committed is available.
    assign outData         = w_out_valid ? r_mem[r_rd[AW-1:0]] : 8'h00;
    assign pktCount        = r_pkt_cnt;
    assign droppedCount    = r_dropped;
    assign dropPulse       = r_drop_pulse;
    assign overflowPulse   = r_ovf_pulse;

    // Store accepted bytes at the tentative write head.
    always_ff @(posedge clk48) begin
        if (w_store && !flush) begin
            r_mem[r_wr[AW-1:0]] <= rxData;
        end
    end

    // Record the end address of each committed packet.
    always_ff @(posedge clk48) begin
        if (w_commit && !flush) begin
            r_endq[r_qwr] <= r_wr;
        end
    end

    // Pointer, slot-queue, packet-state and statistics control.
    always_ff @(posedge clk48 or negedge RST_N) begin
        if (!RST_N) begin
            r_wr         <= '0;
            r_cm         <= '0;
            r_rd         <= '0;
            r_qwr        <= '0;
            r_qrd        <= '0;
            r_pkt_cnt    <= '0;
            r_in_pkt     <= 1'b0;
            r_ovf        <= 1'b0;
            r_discard    <= 1'b0;
            r_accept     <= 1'b0;
            r_drop_pulse <= 1'b0;
            r_ovf_pulse  <= 1'b0;
            r_dropped    <= '0;
        end else begin
            r_accept     <= 1'b1;
            r_drop_pulse <= 1'b0;
            r_ovf_pulse  <= 1'b0;
            if (flush) begin
                r_wr      <= '0;
                r_cm      <= '0;
                r_rd      <= '0;
                r_qwr     <= '0;
                r_qrd     <= '0;
                r_pkt_cnt <= '0;
                r_ovf     <= 1'b0;
                r_in_pkt  <= 1'b0;
                // Swallow the tail of a packet cut by the flush, unless it ends right now.
                r_discard <= (r_in_pkt || r_discard || w_acc) && !(w_acc && rxIsLastByte);
            end else begin
                if (w_rd_adv) begin
                    r_rd <= r_rd + 1'b1;
                end
                if (w_pop) begin
                    r_qrd <= r_qrd + 1'b1;
                end
                if (w_acc && r_discard && rxIsLastByte) begin
                    r_discard <= 1'b0;
                end
                if (w_active) begin
                    r_in_pkt <= !rxIsLastByte;
                end
                if (w_store) begin
                    r_wr <= r_wr + 1'b1;
                end
                if (w_active && !w_store) begin
                    r_ovf <= 1'b1;
                end
                if (w_last) begin
                    r_ovf <= 1'b0;
                end
                if (w_commit) begin
                    r_cm  <= r_wr + 1'b1;
                    r_qwr <= r_qwr + 1'b1;
                end
                if (w_drop) begin
                    r_wr         <= r_cm;
                    r_drop_pulse <= 1'b1;
                    r_ovf_pulse  <= w_ovf_cause;
                    if (r_dropped != '1) begin
                        r_dropped <= r_dropped + 1'b1;
                    end
                end
                r_pkt_cnt <= r_pkt_cnt + (SW+1)'(w_commit) - (SW+1)'(w_pop);
            end
        end
    end

endmodule

// File: tb/tb_usb_sie_rx_packet_buffer.sv
// tb/tb_usb_sie_rx_packet_buffer.sv - directed self-checking bench for usb_sie_rx_packet_buffer
module tb_usb_sie_rx_packet_buffer;

    logic       clk48;
    logic       RST_N;
    logic       flush;
    logic [7:0] rxData;
    logic       rxDataValid;
    logic       rxIsLastByte;
    logic       keepPacket;
    logic       rxAcceptNewData;
    logic [7:0] outData;
    logic       outValid;
    logic       outIsLastByte;
    logic       outReady;
    logic [1:0] pktCount;
    logic [1:0] droppedCount;
    logic       dropPulse;
    logic       overflowPulse;

    int vectors;
    int fails;

    usb_sie_rx_packet_buffer #(.DEPTH(8), .PKT_SLOTS(2), .CNT_W(2)) dut (
        .clk48           (clk48),
        .RST_N           (RST_N),
        .flush           (flush),
        .rxData          (rxData),
        .rxDataValid     (rxDataValid),
        .rxIsLastByte    (rxIsLastByte),
        .keepPacket      (keepPacket),
        .rxAcceptNewData (rxAcceptNewData),
        .outData         (outData),
        .outValid        (outValid),
        .outIsLastByte   (outIsLastByte),
        .outReady        (outReady),
        .pktCount        (pktCount),
        .droppedCount    (droppedCount),
        .dropPulse       (dropPulse),
        .overflowPulse   (overflowPulse)
    );

    initial clk48 = 1'b0;
    always #5 clk48 = ~clk48;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive len bytes; term marks the final one as the end of packet.
    task automatic send_bytes(input logic [63:0] d, input int len, input logic keep, input logic term);
        for (int i = 0; i < len; i++) begin
            @(negedge clk48);
            rxDataValid  = 1'b1;
            rxData       = d[8*i +: 8];
            rxIsLastByte = term && (i == len - 1);
            keepPacket   = keep;
        end
        @(negedge clk48);
        rxDataValid  = 1'b0;
        rxIsLastByte = 1'b0;
        keepPacket   = 1'b0;
    endtask

    // Consume one packet and compare every byte and its end flag.
    task automatic read_pkt(input logic [63:0] d, input int len, input logic stall);
        int idx;
        int budget;
        idx    = 0;
        budget = 0;
        while (idx < len) begin
            @(negedge clk48);
            outReady = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            check("pkt_bound", 32'(pktCount <= 2'd2), 32'd1);
            if (outValid && outReady) begin
                check("rd_data", 32'(outData), 32'(d[8*idx +: 8]));
                check("rd_last", 32'(outIsLastByte), 32'(idx == len - 1));
                idx++;
            end
            budget++;
            if (budget > 200) begin
                check("rd_timeout", 32'd1, 32'd0);
                idx = len;
            end
        end
        @(negedge clk48);
        outReady = 1'b0;
    endtask

    function automatic logic [63:0] wrap_word(input int k);
        logic [63:0] w;
        for (int i = 0; i < 8; i++) begin
            w[8*i +: 8] = 8'(k * 37 + i * 11 + 5);
        end
        return w;
    endfunction

    function automatic int wrap_len(input int k);
        return 1 + ((k * 5 + 1) % 4);
    endfunction

    initial begin
        vectors      = 0;
        fails        = 0;
        RST_N        = 1'b0;
        flush        = 1'b0;
        rxData       = 8'h00;
        rxDataValid  = 1'b0;
        rxIsLastByte = 1'b0;
        keepPacket   = 1'b0;
        outReady     = 1'b0;

        // Reset state
        repeat (3) @(negedge clk48);
        check("rst_accept", 32'(rxAcceptNewData), 32'd0);
        check("rst_valid",  32'(outValid), 32'd0);
        check("rst_data",   32'(outData), 32'd0);
        check("rst_last",   32'(outIsLastByte), 32'd0);
        check("rst_pkts",   32'(pktCount), 32'd0);
        check("rst_drops",  32'(droppedCount), 32'd0);
        check("rst_dpulse", 32'(dropPulse), 32'd0);
        check("rst_opulse", 32'(overflowPulse), 32'd0);
        RST_N = 1'b1;
        @(negedge clk48);
        check("accept_up", 32'(rxAcceptNewData), 32'd1);

        // Good packet C3 01 02 03 04
        send_bytes(64'h04_03_02_01_C3, 5, 1'b1, 1'b1);
        check("good_valid", 32'(outValid), 32'd1);
        check("good_pkts",  32'(pktCount), 32'd1);
        check("good_head",  32'(outData), 32'hC3);
        read_pkt(64'h04_03_02_01_C3, 5, 1'b0);
        check("good_empty", 32'(pktCount), 32'd0);
        check("good_novld", 32'(outValid), 32'd0);

        // Bad CRC followed by a good packet
        send_bytes(64'hDD_CC_BB_AA, 4, 1'b0, 1'b1);
        check("crc_dpulse", 32'(dropPulse), 32'd1);
        check("crc_opulse", 32'(overflowPulse), 32'd0);
        check("crc_drops",  32'(droppedCount), 32'd1);
        check("crc_novld",  32'(outValid), 32'd0);
        @(negedge clk48);
        check("crc_pulse1", 32'(dropPulse), 32'd0);
        send_bytes(64'h33_22_11, 3, 1'b1, 1'b1);
        check("crc_good",   32'(pktCount), 32'd1);
        read_pkt(64'h33_22_11, 3, 1'b0);
        check("crc_drops2", 32'(droppedCount), 32'd1);

        // Overflow: 6 bytes held, 4-byte packet does not fit, then an exact 2-byte fit
        send_bytes(64'h15_14_13_12_11_10, 6, 1'b1, 1'b1);
        check("ovf_pkts1",  32'(pktCount), 32'd1);
        send_bytes(64'h23_22_21_20, 4, 1'b1, 1'b1);
        check("ovf_dpulse", 32'(dropPulse), 32'd1);
        check("ovf_opulse", 32'(overflowPulse), 32'd1);
        check("ovf_drops",  32'(droppedCount), 32'd2);
        check("ovf_pkts2",  32'(pktCount), 32'd1);
        send_bytes(64'h31_30, 2, 1'b1, 1'b1);
        check("ovf_fit",    32'(pktCount), 32'd2);
        check("ovf_fitdp",  32'(dropPulse), 32'd0);
        read_pkt(64'h15_14_13_12_11_10, 6, 1'b0);
        read_pkt(64'h31_30, 2, 1'b0);

        // Slot limit without reads
        send_bytes(64'h41, 1, 1'b1, 1'b1);
        send_bytes(64'h42, 1, 1'b1, 1'b1);
        send_bytes(64'h43, 1, 1'b1, 1'b1);
        check("slot_dpulse", 32'(dropPulse), 32'd1);
        check("slot_opulse", 32'(overflowPulse), 32'd1);
        check("slot_pkts",   32'(pktCount), 32'd2);
        check("slot_drops",  32'(droppedCount), 32'd3);
        read_pkt(64'h41, 1, 1'b0);
        read_pkt(64'h42, 1, 1'b0);

        // Slot limit with a pop on the same cycle as the third commit
        send_bytes(64'h51, 1, 1'b1, 1'b1);
        send_bytes(64'h52, 1, 1'b1, 1'b1);
        @(negedge clk48);
        rxDataValid  = 1'b1;
        rxData       = 8'h53;
        rxIsLastByte = 1'b1;
        keepPacket   = 1'b1;
        outReady     = 1'b1;
        @(negedge clk48);
        rxDataValid  = 1'b0;
        rxIsLastByte = 1'b0;
        keepPacket   = 1'b0;
        outReady     = 1'b0;
        check("pop_dpulse", 32'(dropPulse), 32'd0);
        check("pop_pkts",   32'(pktCount), 32'd2);
        check("pop_drops",  32'(droppedCount), 32'd3);
        check("pop_head",   32'(outData), 32'h52);
        read_pkt(64'h52, 1, 1'b0);
        read_pkt(64'h53, 1, 1'b0);

        // Pointer wrap with concurrent write and read
        send_bytes(wrap_word(0), wrap_len(0), 1'b1, 1'b1);
        for (int k = 0; k < 20; k++) begin
            if (k < 19) begin
                fork
                    send_bytes(wrap_word(k + 1), wrap_len(k + 1), 1'b1, 1'b1);
                    read_pkt(wrap_word(k), wrap_len(k), 1'b1);
                join
            end else begin
                read_pkt(wrap_word(k), wrap_len(k), 1'b1);
            end
        end
        check("wrap_empty", 32'(pktCount), 32'd0);
        check("wrap_drops", 32'(droppedCount), 32'd3);

        // Flush mid-packet
        send_bytes(64'h61, 1, 1'b1, 1'b1);
        check("fl_pre", 32'(pktCount), 32'd1);
        send_bytes(64'h63_62, 2, 1'b1, 1'b0);
        @(negedge clk48);
        flush = 1'b1;
        @(negedge clk48);
        flush = 1'b0;
        check("fl_pkts",  32'(pktCount), 32'd0);
        check("fl_novld", 32'(outValid), 32'd0);
        send_bytes(64'h65_64, 2, 1'b1, 1'b1);
        check("fl_tail",   32'(outValid), 32'd0);
        check("fl_dpulse", 32'(dropPulse), 32'd0);
        check("fl_drops",  32'(droppedCount), 32'd3);
        send_bytes(64'h67_66, 2, 1'b1, 1'b1);
        check("fl_next", 32'(pktCount), 32'd1);
        read_pkt(64'h67_66, 2, 1'b0);

        // Dropped counter saturation
        send_bytes(64'h77, 1, 1'b0, 1'b1);
        check("sat_dpulse", 32'(dropPulse), 32'd1);
        check("sat_drops",  32'(droppedCount), 32'd3);

        // Asynchronous reset mid-read
        send_bytes(64'h73_72_71, 3, 1'b1, 1'b1);
        outReady = 1'b1;
        @(negedge clk48);
        outReady = 1'b0;
        check("ar_mid", 32'(outData), 32'h72);
        #1;
        RST_N = 1'b0;
        #1;
        check("ar_valid",  32'(outValid), 32'd0);
        check("ar_data",   32'(outData), 32'd0);
        check("ar_last",   32'(outIsLastByte), 32'd0);
        check("ar_pkts",   32'(pktCount), 32'd0);
        check("ar_drops",  32'(droppedCount), 32'd0);
        check("ar_accept", 32'(rxAcceptNewData), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/usb_sie_rx_packet_buffer.md
# usb_sie_rx_packet_buffer

Parametrised packet-granular receive buffer between the USB SIE receive byte interface and the upper protocol layers, in the `clk48` domain. Bytes are staged tentatively. Completed packets with `keepPacket` set are committed atomically. Packets with CRC or bit-stuff errors, and packets that overflow the buffer, are rolled back and counted. The consumer only ever sees whole, valid packets, and can hold off reading without stalling the SIE.

## Interface
- `DEPTH`, default 64: data storage in bytes; power of two, ≥ 8.
- `PKT_SLOTS`, default 4: maximum committed packets held at once; power of two, ≥ 2.
- `CNT_W`, default 8: width of the dropped-packet counter.

Ports:
- `clk48`  in  1  system clock, 48 MHz; all logic is on its rising edge.
- `RST_N`  in  1  reset; asynchronous, active-low.
- `flush`  in  1  synchronous discard of all buffered data.
- `rxData`  in  8  byte from the SIE.
- `rxDataValid`  in  1  `rxData` holds a new byte.
- `rxIsLastByte`  in  1  the current byte ends its packet.
- `keepPacket`  in  1  packet-good flag; sampled only with the last byte.
- `rxAcceptNewData`  out  1  ready to the SIE.
- `outData`  out  8  byte at the read head.
- `outValid`  out  1  `outData` is a byte of a committed packet.
- `outIsLastByte`  out  1  `outData` is the final byte of its packet.
- `outReady`  in  1  the consumer takes `outData`.
- `pktCount`  out  log2(PKT_SLOTS)+1  number of committed packets not yet fully read.
- `droppedCount`  out  CNT_W  saturating count of discarded packets.
- `dropPulse`  out  1  one-cycle strobe per discarded packet.
- `overflowPulse`  out  1  one-cycle strobe when a discard is caused by overflow.

## Operation
**Pointers.**
- Write pointer `wr`, commit pointer `cm`, read pointer `rd`; each is log2(DEPTH)+1 bits wide and wraps naturally.
- `used = wr - rd` (modulo). The buffer is full when `used == DEPTH`.

**Accepting bytes.**
- `rxAcceptNewData` is 0 in reset and 1 at all other times; the SIE is never stalled.
- A byte is accepted when `rxDataValid && rxAcceptNewData`.
- An accepted byte while `inPkt` is 0 sets `inPkt`. The last byte clears it.
- If the buffer is not full and `ovf` is 0, the byte is written to `mem[wr]` and `wr` increments.
- If the buffer is full, the byte is discarded and `ovf` is set. `ovf` stays set until the end of the packet.

**End of packet (last byte accepted).**
- Commit if `keepPacket == 1`, `ovf == 0`, this byte was stored, and committed packets are fewer than `PKT_SLOTS` (a pop in the same cycle frees a slot).
- On commit: `cm` takes the post-write `wr`, the end address (`wr` before the increment) is pushed into the end-pointer queue, and `pktCount` increments.
- Otherwise drop: `wr` takes `cm`, `dropPulse` is asserted, and `droppedCount` increments, saturating at all-ones.
- `overflowPulse` is asserted as well if `ovf` was set or the slot queue was full.
- `ovf` clears.

**Read side.**
- `outValid = (pktCount != 0)`.
- `outData = mem[rd]`, read asynchronously.
- `outIsLastByte = outValid && rd == endQueue.head`.
- On `outValid && outReady`: `rd` increments. If the byte is the last byte, the queue pops and `pktCount` decrements.
- A commit and a pop in the same cycle leave `pktCount` unchanged.

**Flush.**
- All pointers go to 0, the queue empties, `pktCount` goes to 0, and `ovf` clears.
- If `inPkt` is set, or a non-last byte is accepted in the same cycle, `discard` is set. Remaining bytes up to and including the last byte are ignored. This discard is not counted as a drop.

**Reset.**
- Every output is 0 and `droppedCount` is 0.
- Internal state: pointers 0, `inPkt`/`ovf`/`discard` 0.
- Buffer memory contents are not reset.

## Timing
- Write to visibility: the last byte accepted at edge N makes the packet visible at `outValid` after edge N. This is 1 cycle of latency, with no cut-through.
- `dropPulse` and `overflowPulse` are registered and high for exactly the cycle after edge N.
- Read throughput is 1 byte/clock. `outData` is valid combinationally while `outValid` is high.
- The consumer may hold `outReady` low indefinitely. The SIE keeps writing until the buffer is full, then packets are dropped.
- The SIE delivers at most one byte per 8 bit-times, which is ≥ 32 `clk48` cycles. The block nevertheless supports back-to-back accepts on consecutive cycles.
- `flush` has priority over an accept and a read in the same cycle.

## Test plan
- **Good packet.** Send 5 bytes `C3 01 02 03 04` with `keepPacket=1` on the last byte, then drain with `outReady=1`. Expect `outValid` the cycle after the last byte, the same 5 bytes in order, `outIsLastByte` on `04`, and `pktCount` 1→0.
- **Bad CRC.** Send a 4-byte packet with `keepPacket=0`, then a 3-byte good packet. Expect `dropPulse` once, `droppedCount=1`, and only the 3-byte packet delivered.
- **Overflow.** `DEPTH=8`, `outReady=0`. Commit a 6-byte packet, then send a 4-byte packet. Expect the second packet dropped with `overflowPulse`; `used` returns to 6. The first packet then reads out intact.
- **Slot limit.** `PKT_SLOTS=2`. Send 3 one-byte good packets without reading. Expect the third dropped. Repeat with a pop on the exact cycle of the third commit; expect all 3 kept.
- **Wrap and simultaneity.** Stream 100 random-length good packets while reading concurrently with random `outReady`. Expect a byte-exact match against a model, pointer wrap exercised, and `pktCount` never exceeding `PKT_SLOTS`.
- **Flush and reset.** Assert `flush` mid-packet; expect the rest of that packet ignored, `droppedCount` unchanged, and the next packet delivered. Assert `RST_N` low mid-read; expect all outputs 0 immediately and asynchronously.
